// File: rtl/hardfloat_result_checker.sv
// In-order result scoreboard for a hardfloat unit: queues expected {ieee, flags}, pairs each DUT result, counts errors.
// Optional macro CHECK_RECODED_EN adds the recoded-format words to the FIFO entry and to the mismatch compare.
module hardfloat_result_checker #(
  parameter int EXP_WIDTH       = 8,
  parameter int SIG_WIDTH       = 24,
  parameter int DEPTH           = 8,
  parameter int MAX_ERRORS      = 20,
  parameter int REPORT_INTERVAL = 10000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           exp_valid,
  output logic                           exp_ready,
  input  logic [EXP_WIDTH+SIG_WIDTH-1:0] expected_ieee,
  input  logic [4:0]                     expected_exception,
`ifdef CHECK_RECODED_EN
  input  logic [EXP_WIDTH+SIG_WIDTH:0]   expected_recoded,
  input  logic [EXP_WIDTH+SIG_WIDTH:0]   actual_recoded,
`endif
  input  logic                           act_valid,
  input  logic [EXP_WIDTH+SIG_WIDTH-1:0] actual_ieee,
  input  logic [4:0]                     actual_exception,
  output logic [31:0]                    test_cnt,
  output logic [15:0]                    err_cnt,
  output logic [31:0]                    first_err_idx,
  output logic [EXP_WIDTH+SIG_WIDTH-1:0] first_err_exp,
  output logic [EXP_WIDTH+SIG_WIDTH-1:0] first_err_act,
  output logic                           underflow,
  output logic                           report_pulse,
  output logic                           abort
);

  localparam int W  = EXP_WIDTH + SIG_WIDTH;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef CHECK_RECODED_EN
  localparam int EW = W + 5 + W + 1;
`else
  localparam int EW = W + 5;
`endif
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [15:0]   ERR_MAX  = 16'(MAX_ERRORS);
  localparam logic [31:0]   RPT_LAST = 32'(REPORT_INTERVAL - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ABORT} state_t;

  state_t        state_q;
  logic          abort_q;
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [31:0]   test_cnt_q, rpt_cnt_q, first_idx_q;
  logic [15:0]   err_cnt_q;
  logic [W-1:0]  first_exp_q, first_act_q;
  logic          underflow_q, hit_q, report_q;

  logic [EW-1:0] exp_entry, act_entry, head;
  logic          fifo_empty, fifo_full, push, cmp_en, pop, mismatch;
  logic [15:0]   err_cnt_d;

`ifdef CHECK_RECODED_EN
  assign exp_entry = {expected_ieee, expected_exception, expected_recoded};
  assign act_entry = {actual_ieee, actual_exception, actual_recoded};
`else
  assign exp_entry = {expected_ieee, expected_exception};
  assign act_entry = {actual_ieee, actual_exception};
`endif

  // Small FIFO is read asynchronously so the head can be compared in the pop cycle.
  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign exp_ready  = (state_q == ST_RUN) && !fifo_full;
  assign push       = exp_valid && exp_ready;
  assign cmp_en     = act_valid && (state_q == ST_RUN);
  assign pop        = cmp_en && !fifo_empty;
  assign mismatch   = fifo_empty || (head != act_entry);
  assign err_cnt_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= exp_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      abort_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      test_cnt_q  <= '0;
      rpt_cnt_q   <= '0;
      err_cnt_q   <= '0;
      first_idx_q <= '0;
      first_exp_q <= '0;
      first_act_q <= '0;
      underflow_q <= 1'b0;
      hit_q       <= 1'b0;
      report_q    <= 1'b0;
    end else begin
      hit_q    <= 1'b0;
      report_q <= hit_q;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (cmp_en && mismatch && (err_cnt_d == ERR_MAX)) begin
            state_q <= ST_ABORT;
            abort_q <= 1'b1;
          end
        end
        default: ;
      endcase

      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_ONE;
      end else if (!push && pop) begin
        count_q <= count_q - CNT_ONE;
      end

      if (cmp_en) begin
        test_cnt_q <= test_cnt_q + 32'd1;
        if (rpt_cnt_q == RPT_LAST) begin
          rpt_cnt_q <= '0;
          hit_q     <= 1'b1;
        end else begin
          rpt_cnt_q <= rpt_cnt_q + 32'd1;
        end
        if (fifo_empty) begin
          underflow_q <= 1'b1;
        end
        // An underflow has no expected word, so its capture records zero.
        if (mismatch) begin
          err_cnt_q <= err_cnt_d;
          if (err_cnt_q == '0) begin
            first_idx_q <= test_cnt_q;
            first_exp_q <= fifo_empty ? '0 : head[EW-1 -: W];
            first_act_q <= actual_ieee;
          end
        end
      end
    end
  end

  assign test_cnt      = test_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_idx_q;
  assign first_err_exp = first_exp_q;
  assign first_err_act = first_act_q;
  assign underflow     = underflow_q;
  assign report_pulse  = report_q;
  assign abort         = abort_q;

endmodule

// File: tb/tb_hardfloat_result_checker.sv
// Scoreboard bench for hardfloat_result_checker: queue-based reference model, randomized pipelined result streams.
module tb_hardfloat_result_checker;
  localparam int DEPTH = 8;
  localparam int MAXE  = 20;
  localparam int RI    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, exp_valid = 1'b0, act_valid = 1'b0;
  logic [31:0] expected_ieee = '0, actual_ieee = '0;
  logic [4:0]  expected_exception = '0, actual_exception = '0;
  logic        exp_ready, underflow, report_pulse, abort;
  logic [31:0] test_cnt, first_err_idx, first_err_exp, first_err_act;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  hardfloat_result_checker #(
    .EXP_WIDTH(8), .SIG_WIDTH(24), .DEPTH(DEPTH), .MAX_ERRORS(MAXE), .REPORT_INTERVAL(RI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .exp_valid(exp_valid), .exp_ready(exp_ready),
    .expected_ieee(expected_ieee), .expected_exception(expected_exception),
    .act_valid(act_valid), .actual_ieee(actual_ieee), .actual_exception(actual_exception),
    .test_cnt(test_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
    .first_err_exp(first_err_exp), .first_err_act(first_err_act),
    .underflow(underflow), .report_pulse(report_pulse), .abort(abort)
  );

  typedef struct {
    logic [31:0] tc;
    logic [15:0] ec;
    logic        uf;
    logic        ab;
    logic [31:0] idx;
    logic [31:0] fe;
    logic [31:0] fa;
  } exp_t;

  typedef struct {
    logic [31:0] ieee;
    logic [4:0]  exc;
  } vec_t;

  exp_t sb[$];
  vec_t mq[$];
  int          m_state;  // 0 idle, 1 run, 2 abort
  logic [31:0] m_tc, m_idx, m_fe, m_fa;
  logic [15:0] m_ec;
  logic        m_uf;
  int          m_pulses = 0, seen_pulses = 0;
  int          checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    sb.delete();
    m_state = 0; m_tc = '0; m_ec = '0; m_uf = 1'b0;
    m_idx = '0; m_fe = '0; m_fa = '0;
    m_pulses = 0; seen_pulses = 0;
  endtask

  // One clock cycle of stimulus; the reference model advances on the same inputs.
  task automatic drive(input logic st, input logic ev, input logic [31:0] ei, input logic [4:0] ee,
                       input logic av, input logic [31:0] ai, input logic [4:0] ae);
    bit   ready, mis;
    vec_t h, nv;
    exp_t e;
    @(posedge clk); #1;
    start = st; exp_valid = ev; expected_ieee = ei; expected_exception = ee;
    act_valid = av; actual_ieee = ai; actual_exception = ae;
    ready = (m_state == 1) && (mq.size() < DEPTH);
    check("exp_ready", 32'(exp_ready), 32'(ready));
    if (av && m_state == 1) begin
      if (mq.size() == 0) begin
        m_uf = 1'b1; mis = 1'b1; h.ieee = '0; h.exc = '0;
      end else begin
        h = mq.pop_front();
        mis = (h.ieee != ai) || (h.exc != ae);
      end
      if (mis) begin
        if (m_ec == 0) begin
          m_idx = m_tc; m_fe = h.ieee; m_fa = ai;
        end
        if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
        if (m_ec == 16'(MAXE)) m_state = 2;
      end
      m_tc = m_tc + 32'd1;
      if (m_tc % RI == 0) m_pulses++;
    end
    if (ev && ready) begin
      nv.ieee = ei; nv.exc = ee;
      mq.push_back(nv);
    end
    if (st && m_state == 0) m_state = 1;
    if (av) begin
      e.tc = m_tc; e.ec = m_ec; e.uf = m_uf; e.ab = (m_state == 2);
      e.idx = m_idx; e.fe = m_fe; e.fa = m_fa;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0; start = 1'b0; exp_valid = 1'b0; act_valid = 1'b0;
    #1;
    check("rst_test_cnt", test_cnt, 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_first_idx", first_err_idx, 32'd0);
    check("rst_first_exp", first_err_exp, 32'd0);
    check("rst_first_act", first_err_act, 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_report", 32'(report_pulse), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    check("rst_exp_ready", 32'(exp_ready), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    model_clear();
  endtask

  // Issue n vectors; the matching results arrive lat cycles later, some corrupted.
  task automatic pipe(input int n, input int lat, input int err_pct);
    vec_t ex[64];
    vec_t ac[64];
    logic        ev, av;
    logic [31:0] ei, ai;
    logic [4:0]  ee, ae;
    for (int i = 0; i < n; i++) begin
      ex[i].ieee = $urandom;
      ex[i].exc  = 5'($urandom_range(0, 31));
      ac[i] = ex[i];
      if ($urandom_range(0, 99) < err_pct) begin
        if ($urandom_range(0, 1) == 1) ac[i].ieee = ac[i].ieee ^ (32'd1 << $urandom_range(0, 31));
        else ac[i].exc = ac[i].exc ^ (5'd1 << $urandom_range(0, 4));
      end
    end
    for (int c = 0; c < n + lat; c++) begin
      ev = (c < n);
      av = (c >= lat);
      ei = ev ? ex[c].ieee : '0;
      ee = ev ? ex[c].exc : '0;
      ai = av ? ac[c-lat].ieee : '0;
      ae = av ? ac[c-lat].exc : '0;
      drive(0, ev, ei, ee, av, ai, ae);
    end
  endtask

  // Monitor: counters reflect a result the cycle after act_valid is sampled.
  logic act_d1;
  exp_t mon_e;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) act_d1 <= 1'b0;
    else        act_d1 <= act_valid;
  end

  always @(negedge clk) begin
    if (rst_n && report_pulse) seen_pulses++;
    if (act_d1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underrun: got a DUT result, expected none queued");
      end else begin
        mon_e = sb.pop_front();
        check("test_cnt", test_cnt, mon_e.tc);
        check("err_cnt", 32'(err_cnt), 32'(mon_e.ec));
        check("underflow", 32'(underflow), 32'(mon_e.uf));
        check("abort", 32'(abort), 32'(mon_e.ab));
        check("first_err_idx", first_err_idx, mon_e.idx);
        check("first_err_exp", first_err_exp, mon_e.fe);
        check("first_err_act", first_err_act, mon_e.fa);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t fill[8];
    // Phase A: idle behaviour, basic matches, pipelined matches
    do_reset();
    drive(0, 1, 32'h3F800000, 5'h0, 1, 32'h3F800000, 5'h0);
    drive(1, 0, '0, '0, 0, '0, '0);
    for (int i = 0; i < 3; i++) drive(0, 1, 32'h3F800000, 5'h0, 0, '0, '0);
    for (int i = 0; i < 3; i++) drive(0, 0, '0, '0, 1, 32'h3F800000, 5'h0);
    idle(2);
    check("basic_test_cnt", test_cnt, 32'd3);
    pipe(4, 4, 0);
    for (int i = 0; i < 6; i++) pipe($urandom_range(1, 12), $urandom_range(1, 4), 0);
    idle(3);
    check("phaseA_err_cnt", 32'(err_cnt), 32'd0);
    check("phaseA_pulses", 32'(seen_pulses), 32'(m_pulses));

    // Phase B: first-mismatch capture, flag mismatch, abort and freeze
    do_reset();
    drive(1, 0, '0, '0, 0, '0, '0);
    for (int i = 0; i < 3; i++) drive(0, 1, 32'h3F800000, 5'h0, 0, '0, '0);
    drive(0, 0, '0, '0, 1, 32'h3F800000, 5'h0);
    drive(0, 0, '0, '0, 1, 32'h3F800001, 5'h0);
    drive(0, 0, '0, '0, 1, 32'h3F800000, 5'h0);
    idle(2);
    check("capture_idx", first_err_idx, 32'd1);
    check("capture_exp", first_err_exp, 32'h3F800000);
    check("capture_act", first_err_act, 32'h3F800001);
    drive(0, 1, 32'h40000000, 5'h01, 0, '0, '0);
    drive(0, 0, '0, '0, 1, 32'h40000000, 5'h00);
    idle(2);
    check("flag_mismatch_err_cnt", 32'(err_cnt), 32'd2);
    for (int i = 0; i < 40 && m_state != 2; i++) pipe(8, $urandom_range(1, 4), 50);
    idle(2);
    check("abort_raised", 32'(abort), 32'd1);
    check("abort_err_cnt", 32'(err_cnt), 32'(MAXE));
    for (int i = 0; i < 5; i++) drive(0, 1, $urandom, 5'h0, 1, $urandom, 5'h1);
    idle(3);
    check("phaseB_pulses", 32'(seen_pulses), 32'(m_pulses));

    // Phase C: underflow, full FIFO, mid-stream reset
    do_reset();
    drive(1, 0, '0, '0, 0, '0, '0);
    drive(0, 0, '0, '0, 1, 32'hDEADBEEF, 5'h3);
    idle(2);
    check("uf_flag", 32'(underflow), 32'd1);
    check("uf_err_cnt", 32'(err_cnt), 32'd1);
    check("uf_test_cnt", test_cnt, 32'd1);
    for (int i = 0; i < 8; i++) begin
      fill[i].ieee = $urandom;
      fill[i].exc  = 5'($urandom_range(0, 31));
      drive(0, 1, fill[i].ieee, fill[i].exc, 0, '0, '0);
    end
    idle(1);
    check("full_exp_ready", 32'(exp_ready), 32'd0);
    drive(0, 1, 32'h12345678, 5'h0, 1, fill[0].ieee, fill[0].exc);
    drive(0, 0, '0, '0, 1, fill[1].ieee, fill[1].exc);
    drive(0, 0, '0, '0, 1, fill[2].ieee, fill[2].exc);
    idle(3);
    check("phaseC_err_cnt", 32'(err_cnt), 32'd1);
    check("phaseC_pulses", 32'(seen_pulses), 32'(m_pulses));
    do_reset();
    idle(1);
    drive(1, 0, '0, '0, 0, '0, '0);
    drive(0, 0, '0, '0, 1, fill[3].ieee, fill[3].exc);
    idle(3);
    check("post_reset_underflow", 32'(underflow), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
